// File: rtl/alu_seq_pkg.sv
// Shared constants and state type for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [2:0] FN_AND  = 3'd0;
  localparam logic [2:0] FN_OR   = 3'd1;
  localparam logic [2:0] FN_ADD  = 3'd2;
  localparam logic [2:0] FN_SUB  = 3'd3;
  localparam logic [2:0] FN_SLT  = 3'd4;
  localparam logic [2:0] FN_NOR  = 3'd5;
  localparam logic [2:0] FN_MUL  = 3'd6;
  localparam logic [2:0] FN_RSVD = 3'd7;

  localparam logic [1:0] ALUOP_AND = 2'b00;
  localparam logic [1:0] ALUOP_OR  = 2'b01;
  localparam logic [1:0] ALUOP_ADD = 2'b10;
  localparam logic [1:0] ALUOP_SLT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps a function code onto the ALU invert/select controls.
module alu_ctrl_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] fn,
  output logic       ainvert,
  output logic       binvert,
  output logic [1:0] op
);

  always_comb begin
    ainvert = 1'b0;
    binvert = 1'b0;
    op      = ALUOP_AND;
    case (fn)
      FN_AND: op = ALUOP_AND;
      FN_OR:  op = ALUOP_OR;
      // Multiply steps are plain additions through the same adder.
      FN_ADD, FN_MUL: op = ALUOP_ADD;
      FN_SUB: begin
        binvert = 1'b1;
        op      = ALUOP_ADD;
      end
      FN_SLT: begin
        binvert = 1'b1;
        op      = ALUOP_SLT;
      end
      FN_NOR: begin
        ainvert = 1'b1;
        binvert = 1'b1;
        op      = ALUOP_AND;
      end
      default: op = ALUOP_AND;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command/response sequencer driving an external 8-bit ALU, including
// an 8-step shift-add multiply that reuses the ALU adder.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_fn,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [7:0]  alu_src1,
  output logic [7:0]  alu_src2,
  output logic        alu_ainvert,
  output logic        alu_binvert,
  output logic [1:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_err
);

  seq_state_e  state_reg;
  logic [2:0]  fn_reg;
  logic [7:0]  m_reg;
  logic [7:0]  q_reg;
  logic [7:0]  acc_reg;
  logic [2:0]  iter_reg;
  logic [15:0] rsp_data_reg;
  logic        rsp_zero_reg;
  logic        rsp_overflow_reg;
  logic        rsp_err_reg;

  logic        dec_ainvert;
  logic        dec_binvert;
  logic [1:0]  dec_op;
  logic        mul_carry;
  logic [7:0]  acc_next;
  logic [7:0]  q_next;

  alu_ctrl_decode u_decode (
    .fn      (fn_reg),
    .ainvert (dec_ainvert),
    .binvert (dec_binvert),
    .op      (dec_op)
  );

  assign cmd_ready    = (state_reg == ST_IDLE);
  assign rsp_valid    = (state_reg == ST_RESP);
  assign rsp_data     = rsp_data_reg;
  assign rsp_zero     = rsp_zero_reg;
  assign rsp_overflow = rsp_overflow_reg;
  assign rsp_err      = rsp_err_reg;

  // In EXEC m/q hold the raw operands; in MUL they are multiplicand and
  // shifting multiplier, with acc as the running upper half.
  always_comb begin
    alu_src1    = 8'h00;
    alu_src2    = 8'h00;
    alu_ainvert = 1'b0;
    alu_binvert = 1'b0;
    alu_op      = 2'b00;
    if (state_reg == ST_EXEC) begin
      alu_src1    = m_reg;
      alu_src2    = q_reg;
      alu_ainvert = dec_ainvert;
      alu_binvert = dec_binvert;
      alu_op      = dec_op;
    end else if (state_reg == ST_MUL) begin
      alu_src1    = acc_reg;
      alu_src2    = q_reg[0] ? m_reg : 8'h00;
      alu_ainvert = dec_ainvert;
      alu_binvert = dec_binvert;
      alu_op      = dec_op;
    end
  end

  // The ALU exposes no carry-out, so recover it from the operand MSBs.
  assign mul_carry = (alu_src1[7] & alu_src2[7]) |
                     ((alu_src1[7] ^ alu_src2[7]) & ~alu_result[7]);
  assign acc_next  = {mul_carry, alu_result[7:1]};
  assign q_next    = {alu_result[0], q_reg[7:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      fn_reg           <= FN_AND;
      m_reg            <= 8'h00;
      q_reg            <= 8'h00;
      acc_reg          <= 8'h00;
      iter_reg         <= 3'd0;
      rsp_data_reg     <= 16'h0000;
      rsp_zero_reg     <= 1'b0;
      rsp_overflow_reg <= 1'b0;
      rsp_err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            fn_reg   <= cmd_fn;
            m_reg    <= cmd_a;
            q_reg    <= cmd_b;
            acc_reg  <= 8'h00;
            iter_reg <= 3'd0;
            if (cmd_fn == FN_RSVD) begin
              rsp_data_reg     <= 16'h0000;
              rsp_zero_reg     <= 1'b0;
              rsp_overflow_reg <= 1'b0;
              rsp_err_reg      <= 1'b1;
              state_reg        <= ST_RESP;
            end else if (cmd_fn == FN_MUL) begin
              state_reg <= ST_MUL;
            end else begin
              state_reg <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          rsp_data_reg     <= {8'h00, alu_result};
          rsp_zero_reg     <= alu_zero;
          rsp_overflow_reg <= alu_overflow;
          rsp_err_reg      <= 1'b0;
          state_reg        <= ST_RESP;
        end
        ST_MUL: begin
          acc_reg  <= acc_next;
          q_reg    <= q_next;
          iter_reg <= iter_reg + 3'd1;
          if (iter_reg == 3'd7) begin
            rsp_data_reg     <= {acc_next, q_next};
            rsp_zero_reg     <= ({acc_next, q_next} == 16'h0000);
            rsp_overflow_reg <= (acc_next != 8'h00);
            rsp_err_reg      <= 1'b0;
            state_reg        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
